// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV64 integer register file.
// The register index, the array type and the read-port mux live here so that
// the RTL and the bench agree on every width.
package register_file_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_idx_t REG_ZERO = '0;

    // x0 has no storage, so the array starts at index 1.
    typedef xlen_t reg_array_t [1:NUM_REGS-1];

    function automatic xlen_t read_mux(input reg_array_t regs, input reg_idx_t idx);
        xlen_t value;
        value = '0;
        if (idx != REG_ZERO) begin
            value = regs[idx];
        end
        return value;
    endfunction

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Bus between the pipeline (master) and the register file (slave): one
// write port from writeback and two combinational read ports.
interface register_file_if;
    import register_file_pkg::*;

    logic     RegWrite;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    xlen_t    write_data;
    xlen_t    read_data1;
    xlen_t    read_data2;

    modport master (
        output RegWrite,
        output rs1,
        output rs2,
        output rd,
        output write_data,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  RegWrite,
        input  rs1,
        input  rs2,
        input  rd,
        input  write_data,
        output read_data1,
        output read_data2
    );

endinterface : register_file_if

// File: rtl/register_file.sv
// 32 x 64-bit RISC-V integer register file: x0 hardwired to zero, one
// synchronous write port, two combinational read ports with no write bypass.
module register_file
    import register_file_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave bus
);

    reg_array_t r_regs;
    logic       w_wr_en;

    // x0 writes are dropped here, so x0 never needs a storage slot.
    assign w_wr_en = bus.RegWrite && (bus.rd != REG_ZERO);

    // NOTE: the whole array is cleared by the async reset on purpose; reads
    // must return zero during reset, so this cannot be left to a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            // NOTE: non-blocking so a same-cycle read sees the old value.
            r_regs[bus.rd] <= bus.write_data;
        end
    end

    assign bus.read_data1 = read_mux(r_regs, bus.rs1);
    assign bus.read_data2 = read_mux(r_regs, bus.rs2);

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    import register_file_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input xlen_t got, input xlen_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a write between edges, take it on the next rising edge.
    task automatic do_write(input reg_idx_t idx, input xlen_t data);
        @(negedge clk);
        bus.RegWrite   = 1'b1;
        bus.rd         = idx;
        bus.write_data = data;
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
    endtask

    task automatic read_both(input reg_idx_t idx, input xlen_t exp, input string tag);
        bus.rs1 = idx;
        bus.rs2 = idx;
        #1;
        check({tag, "_rd1"}, bus.read_data1, exp);
        check({tag, "_rd2"}, bus.read_data2, exp);
    endtask

    initial begin
        xlen_t ones;
        xlen_t pattern;
        n_checks       = 0;
        n_fail         = 0;
        ones           = '1;
        pattern        = 64'h0101_0101_0101_0101;
        rst_n          = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.rd         = '0;
        bus.write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load nonzero state, then reset with a write pending to x5.
        do_write(5'd5, 64'd1234);
        do_write(5'd7, 64'd55);
        read_both(5'd5, 64'd1234, "pre_reset_x5");
        @(negedge clk);
        bus.RegWrite   = 1'b1;
        bus.rd         = 5'd5;
        bus.write_data = 64'd77;
        rst_n          = 1'b0;
        bus.rs1        = 5'd5;
        bus.rs2        = 5'd7;
        #1;
        check("in_reset_x5", bus.read_data1, 64'd0);
        check("in_reset_x7", bus.read_data2, 64'd0);
        @(posedge clk);
        #1;
        check("reset_blocks_write", bus.read_data1, 64'd0);
        bus.RegWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            read_both(reg_idx_t'(i), 64'd0, "post_reset");
        end

        // Basic write then read on both ports.
        do_write(5'd1, 64'd17600);
        do_write(5'd2, 64'd298700);
        bus.rs1 = 5'd1;
        bus.rs2 = 5'd2;
        #1;
        check("basic_x1", bus.read_data1, 64'd17600);
        check("basic_x2", bus.read_data2, 64'd298700);

        // x0 stays zero.
        do_write(5'd0, 64'd999);
        read_both(5'd0, 64'd0, "x0_hardwired");

        // Write disabled.
        @(negedge clk);
        bus.RegWrite   = 1'b0;
        bus.rd         = 5'd3;
        bus.write_data = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        #1;
        read_both(5'd3, 64'd0, "wr_disable_x3");

        // Collision: old value before the edge, new value after.
        @(negedge clk);
        bus.rs1        = 5'd4;
        bus.rs2        = 5'd4;
        bus.RegWrite   = 1'b1;
        bus.rd         = 5'd4;
        bus.write_data = ones;
        #1;
        check("collide_pre_rd1", bus.read_data1, 64'd0);
        check("collide_pre_rd2", bus.read_data2, 64'd0);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        check("collide_post_rd1", bus.read_data1, ones);
        check("collide_post_rd2", bus.read_data2, ones);

        // Full sweep: xi = i * 0x0101..01.
        for (int i = 1; i < NUM_REGS; i++) begin
            do_write(reg_idx_t'(i), xlen_t'(i) * pattern);
        end
        read_both(5'd0, 64'd0, "sweep_x0");
        check("sweep_x31_const", bus.read_data1, 64'd0);
        for (int i = 1; i < NUM_REGS; i++) begin
            read_both(reg_idx_t'(i), xlen_t'(i) * pattern, "sweep");
        end
        bus.rs1 = 5'd31;
        bus.rs2 = 5'd1;
        #1;
        check("sweep_x31", bus.read_data1, 64'h1F1F_1F1F_1F1F_1F1F);
        check("sweep_x1", bus.read_data2, 64'h0101_0101_0101_0101);

        // Async reset between edges clears reads before the next edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_x31", bus.read_data1, 64'd0);
        check("async_x1", bus.read_data2, 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            read_both(reg_idx_t'(i), 64'd0, "async_sweep");
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_both(5'd16, 64'd0, "after_async_x16");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the 64-bit RISC-V datapath: 32 general-purpose registers x0..x31, each 64 bits wide.
- Two combinational read ports (rs1, rs2) feed the ALU and branch logic.
- One synchronous write port (rd) is driven by the writeback stage.
- x0 is hardwired to zero per the RISC-V ISA.

Parameters:
- XLEN, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegWrite  input  1  write enable from control unit.
- rs1  input  ADDR_W  read port 1 register index.
- rs2  input  ADDR_W  read port 2 register index.
- rd  input  ADDR_W  write port register index.
- write_data  input  XLEN  data to write to register rd.
- read_data1  output  XLEN  contents of register rs1.
- read_data2  output  XLEN  contents of register rs2.

Behaviour:
- Reset: rst_n low clears all registers x1..x31 to 0 immediately, without waiting for clk.
  - While rst_n is low, writes are ignored.
  - Both read ports return 0 for every index while in reset.
- Reset deassertion: rst_n is synchronised externally. The first write can occur on the first rising clk edge after rst_n is high.
- Write: on rising clk, when rst_n=1, RegWrite=1 and rd!=0, register[rd] <= write_data.
  - When RegWrite=0, no register changes.
- x0: a write with rd=0 is discarded. read_data for index 0 is always 0 and does not depend on stored state. No storage is required for x0.
- Read: purely combinational, zero latency.
  - read_data1 = (rs1==0) ? 0 : register[rs1]; read_data2 likewise for rs2.
  - Outputs update whenever rs1/rs2 or register contents change.
- Read/write collision: no internal bypass.
  - If rs1 or rs2 equals rd in the cycle of a write, the read port shows the old value until the rising edge.
  - After the edge, it shows write_data.
  - Forwarding is the pipeline's responsibility.
- Both read ports may address the same register simultaneously; both return identical values.
- Writes are full-width (XLEN bits). There are no byte enables and no sign or zero extension.
- Index range: all 32 encodings of a 5-bit index are valid. There is no out-of-range condition.
- Reset asserted mid-cycle while RegWrite=1:
  - Reset wins; the register array goes to all zeros.
  - The pending write is lost.

Decomposition:
- Shared package (riscv_pkg): XLEN, NUM_REGS, REG_ADDR_W, REG_ZERO (5'd0) constants, and a typedef for the register index.
- No sub-module; the array, write decoder and two read muxes form a single module.
- Optionally split one reusable read-port mux function, used twice.

Test Plan:
- Reset: assert rst_n=0 with prior nonzero contents, release, read x1..x31 → all read 0. During reset, a RegWrite=1 to rd=5 has no effect.
- Basic write/read:
  - Write x1=17600 then x2=298700 on consecutive edges with RegWrite=1.
  - Then set RegWrite=0 and rs1=1, rs2=2 → read_data1=17600, read_data2=298700.
- x0 hardwired: RegWrite=1, rd=0, write_data=999, clock edge, rs1=0 → read_data1=0. Also drive rs2=0 → 0.
- Write disable: RegWrite=0, rd=3, write_data=64'hDEAD_BEEF_0000_0001, clock → x3 still 0.
- Collision timing: hold rs1=4, write x4=64'hFFFF_FFFF_FFFF_FFFF.
  - Before the edge, read_data1 = old value (0).
  - After the edge, read_data1 = all ones. Same index on rs2 gives an identical result.
- Full sweep and async reset:
  - Write xi = i*64'h0101_0101_0101_0101 for i=1..31, then read every index on both ports → matching values; x0 = 0.
  - Then pulse rst_n low between clock edges → all reads 0 immediately, before the next clk edge.
